detect_arbiter: RTL and testbench

DETECT_ARBITER -- requirements
Module: detect_arbiter

---
 rtl/detect_arbiter.sv | 115 +++++++++++
 tb/tb_detect_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_arbiter.sv
// Two-requester round-robin arbiter feeding a registered 4-bit pattern detector,
// with one saturating match counter per requester.
module detect_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             req0,
    input  logic [3:0]       x0,
    input  logic             req1,
    input  logic [3:0]       x1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done,
    output logic             y,
    output logic             src,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e           state_q, state_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done_q, done_d, y_q, y_d;
    logic             src_q, src_d, last_q, last_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             hit, win;

    assign hit = op_q inside {4'd3, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11};
    // On a tie the requester not served last wins; otherwise the sole requester wins.
    assign win = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done_d  = 1'b0;
        y_d     = y_q;
        src_d   = src_q;
        last_d  = last_q;
        op_d    = op_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    src_d   = win;
                    last_d  = win;
                    op_d    = win ? x1 : x0;
                    state_d = StEval;
                end
            end
            StEval: begin
                y_d     = hit;
                done_d  = 1'b1;
                state_d = StDone;
                if (hit) begin
                    if (src_q) begin
                        if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
                    end else begin
                        if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= 1'b0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= 4'd0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done_q  <= done_d;
            y_q     <= y_d;
            src_q   <= src_d;
            last_q  <= last_d;
            op_q    <= op_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign done = done_q;
    assign y    = y_q;
    assign src  = src_q;
    assign busy = (state_q != StIdle);
    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_detect_arbiter.sv
// Bench for detect_arbiter: a default-width and a 2-bit-counter instance share stimulus;
// expected {src,y} pairs are queued at request time and popped at the done pulse.
module tb_detect_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0;
    logic [3:0] x0 = 4'd0, x1 = 4'd0;

    logic gnt0, gnt1, done, y, src, busy;
    logic [7:0] cnt0, cnt1;
    logic s_gnt0, s_gnt1, s_done, s_y, s_src, s_busy;
    logic [1:0] s_cnt0, s_cnt1;

    int n_tests = 0;
    int n_fail = 0;

    logic [15:0] match_tbl = 16'h0EC8;  // bits 3,6,7,9,10,11
    logic [1:0]  sb_q[$];               // {src, y}
    logic        tb_last;
    int          exp_c0, exp_c1, exp_c0s, exp_c1s;

    detect_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req0(req0), .x0(x0), .req1(req1), .x1(x1),
        .gnt0(gnt0), .gnt1(gnt1), .done(done), .y(y), .src(src), .busy(busy),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    detect_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req0(req0), .x0(x0), .req1(req1), .x1(x1),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .done(s_done), .y(s_y), .src(s_src), .busy(s_busy),
        .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; req0 = 1'b0; req1 = 1'b0; x0 = 4'd0; x1 = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tb_last = 1'b1;
        exp_c0 = 0; exp_c1 = 0; exp_c0s = 0; exp_c1s = 0;
        sb_q.delete();
    endtask

    // Drives one request, queues the expected result and samples outputs at k, k+1, k+2.
    task automatic issue(input logic r0, input logic [3:0] a0, input logic r1,
                         input logic [3:0] a1, input logic clr_mid,
                         output logic g0, output logic g1, output logic d1, output logic y1,
                         output logic s1, output logic d2, output logic b2);
        logic w, m;
        @(negedge clk);
        req0 = r0; x0 = a0; req1 = r1; x1 = a1;
        w = (r0 && r1) ? ~tb_last : r1;
        tb_last = w;
        m = match_tbl[w ? a1 : a0];
        sb_q.push_back({w, m});
        @(negedge clk);
        g0 = gnt0; g1 = gnt1;
        req0 = 1'b0; req1 = 1'b0; x0 = ~a0; x1 = ~a1;
        clr = clr_mid;
        @(negedge clk);
        d1 = done; y1 = y; s1 = src;
        clr = 1'b0;
        if (m) begin
            if (w) begin
                exp_c1++; if (exp_c1s < 3) exp_c1s++;
            end else begin
                exp_c0++; if (exp_c0s < 3) exp_c0s++;
            end
        end
        if (clr_mid) begin
            exp_c0 = 0; exp_c1 = 0; exp_c0s = 0; exp_c1s = 0;
        end
        @(negedge clk);
        d2 = done; b2 = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt0, gnt1, done, y, src, busy, cnt0, cnt1} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {gnt0, gnt1, done, y, src, busy, cnt0, cnt1});
        end
        n_tests++;
        if ({s_gnt0, s_gnt1, s_done, s_y, s_src, s_busy, s_cnt0, s_cnt1} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_small: got %b, want all zero",
                     {s_gnt0, s_gnt1, s_done, s_y, s_src, s_busy, s_cnt0, s_cnt1});
        end
        do_reset();
    endtask

    task automatic test_match0();
        logic g0, g1, d1, y1, s1, d2, b2;
        logic [1:0] exp;
        issue(1'b1, 4'b0110, 1'b0, 4'd0, 1'b0, g0, g1, d1, y1, s1, d2, b2);
        n_tests++;
        if ({g0, g1} !== 2'b10) begin
            n_fail++; $display("FAIL match0_grant: got %b, want 10", {g0, g1});
        end
        exp = sb_q.pop_front();
        n_tests++;
        if ({d1, s1, y1} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL match0_result: got %b, want %b", {d1, s1, y1}, {1'b1, exp});
        end
        n_tests++;
        if (cnt0 !== 8'(exp_c0)) begin
            n_fail++; $display("FAIL match0_cnt0: got %0d, want %0d", cnt0, exp_c0);
        end
        n_tests++;
        if ({d2, b2} !== 2'b00) begin
            n_fail++; $display("FAIL match0_idle: got done,busy=%b, want 00", {d2, b2});
        end
    endtask

    task automatic test_nomatch1();
        logic g0, g1, d1, y1, s1, d2, b2;
        logic [1:0] exp;
        issue(1'b0, 4'd0, 1'b1, 4'b0101, 1'b0, g0, g1, d1, y1, s1, d2, b2);
        n_tests++;
        if ({g0, g1} !== 2'b01) begin
            n_fail++; $display("FAIL nomatch1_grant: got %b, want 01", {g0, g1});
        end
        exp = sb_q.pop_front();
        n_tests++;
        if ({d1, s1, y1} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL nomatch1_result: got %b, want %b", {d1, s1, y1}, {1'b1, exp});
        end
        n_tests++;
        if (cnt1 !== 8'(exp_c1)) begin
            n_fail++; $display("FAIL nomatch1_cnt1: got %0d, want %0d", cnt1, exp_c1);
        end
    endtask

    task automatic test_all16();
        logic g0, g1, d1, y1, s1, d2, b2;
        logic [1:0] exp;
        do_reset();
        for (int v = 0; v < 16; v++) begin
            issue(1'b1, 4'(v), 1'b0, 4'd0, 1'b0, g0, g1, d1, y1, s1, d2, b2);
            exp = sb_q.pop_front();
            n_tests++;
            if ({d1, s1, y1} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL all16_x%0d: got done,src,y=%b, want %b", v, {d1, s1, y1},
                         {1'b1, exp});
            end
        end
        n_tests++;
        if (cnt0 !== 8'd6 || exp_c0 != 6) begin
            n_fail++; $display("FAIL all16_cnt0: got %0d, want 6", cnt0);
        end
    endtask

    task automatic test_saturate();
        logic g0, g1, d1, y1, s1, d2, b2;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, g0, g1, d1, y1, s1, d2, b2);
            void'(sb_q.pop_front());
        end
        n_tests++;
        if (s_cnt0 !== 2'd3 || s_cnt0 !== 2'(exp_c0s)) begin
            n_fail++; $display("FAIL sat_cnt0_small: got %0d, want 3", s_cnt0);
        end
        n_tests++;
        if (cnt0 !== 8'(exp_c0)) begin
            n_fail++; $display("FAIL sat_cnt0_wide: got %0d, want %0d", cnt0, exp_c0);
        end
        issue(1'b1, 4'd10, 1'b0, 4'd0, 1'b1, g0, g1, d1, y1, s1, d2, b2);
        void'(sb_q.pop_front());
        n_tests++;
        if (d1 !== 1'b1 || y1 !== 1'b1) begin
            n_fail++; $display("FAIL clr_done: got done,y=%b, want 11", {d1, y1});
        end
        n_tests++;
        if (s_cnt0 !== 2'd0 || cnt0 !== 8'd0) begin
            n_fail++; $display("FAIL clr_priority: got %0d/%0d, want 0/0", s_cnt0, cnt0);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] want;
        do_reset();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; x0 = 4'd3; x1 = 4'd6;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i % 3 != 0) want = 2'b00;
            else want = ((i / 3) % 2 == 0) ? 2'b10 : 2'b01;
            n_tests++;
            if ({gnt0, gnt1} !== want) begin
                n_fail++;
                $display("FAIL alternate_c%0d: got gnt0,gnt1=%b, want %b", i, {gnt0, gnt1}, want);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic g0, g1, d1, y1, s1, d2, b2;
        logic [1:0] exp;
        do_reset();
        @(negedge clk);
        req0 = 1'b1; x0 = 4'd3;
        @(negedge clk);
        n_tests++;
        if ({gnt0, busy} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_eval: got gnt0,busy=%b, want 11", {gnt0, busy});
        end
        req0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({gnt0, gnt1, done, y, src, busy, cnt0, cnt1} !== 22'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b, want all zero",
                     {gnt0, gnt1, done, y, src, busy, cnt0, cnt1});
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_nodone: got done,busy=%b, want 00", {done, busy});
        end
        rst_n = 1'b1;
        tb_last = 1'b1;
        exp_c0 = 0; exp_c1 = 0; exp_c0s = 0; exp_c1s = 0;
        sb_q.delete();
        issue(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, g0, g1, d1, y1, s1, d2, b2);
        n_tests++;
        if ({g0, g1} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_regrant: got %b, want 10", {g0, g1});
        end
        exp = sb_q.pop_front();
        n_tests++;
        if ({d1, s1, y1} !== {1'b1, exp} || cnt0 !== 8'(exp_c0)) begin
            n_fail++;
            $display("FAIL rstmid_result: got %b cnt0=%0d, want %b cnt0=%0d", {d1, s1, y1},
                     cnt0, {1'b1, exp}, exp_c0);
        end
    endtask

    initial begin
        test_reset();
        test_match0();
        test_nomatch1();
        test_all16();
        test_saturate();
        test_alternate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
